// File: rtl/deser_trama_if.sv
// Serial-in / word-out bus of the frame deserializer.
// The master modport is the deserializer side, the slave modport is the consumer/line side.
interface deser_trama_if #(
    parameter int ANCHO     = 8,
    parameter int ANCHO_CNT = 8
);
    logic                 s_in;
    logic                 valido;
    logic                 listo;
    logic [ANCHO-1:0]     dato;
    logic                 dato_valido;
    logic                 fin_trama;
    logic                 trama_incompleta;
    logic [ANCHO_CNT-1:0] num_palabras;
    logic                 desborde;

    modport master (
        input  s_in, valido, listo,
        output dato, dato_valido, fin_trama, trama_incompleta, num_palabras, desborde
    );

    modport slave (
        output s_in, valido, listo,
        input  dato, dato_valido, fin_trama, trama_incompleta, num_palabras, desborde
    );
endinterface

// File: rtl/deser_trama.sv
// Serial-to-parallel frame receiver behind the sequence detector: MSB-first words,
// one-deep valid/ready output register, end-of-frame word count and overflow report.
//
//   state  | meaning
//   ESPERA | idle; first bit of a frame is captured on the edge leaving this state
//   RECIBE | shifting bits while valido is high
//   FIN    | one-cycle end-of-frame; inputs ignored, partial bits cleared
module deser_trama #(
    parameter int ANCHO     = 8,
    parameter int ANCHO_CNT = 8
) (
    input  logic          clk,
    input  logic          rst,
    deser_trama_if.master bus
);
    localparam int                  ANCHO_BC = (ANCHO > 2) ? $clog2(ANCHO) : 1;
    localparam logic [ANCHO_BC-1:0] BC_ULT   = ANCHO_BC'(ANCHO - 1);

    localparam logic [2:0] ESPERA = 3'b001;
    localparam logic [2:0] RECIBE = 3'b010;
    localparam logic [2:0] FIN    = 3'b100;

    logic [2:0]           r_estado;
    logic [2:0]           w_estado_sig;
    logic [ANCHO-1:0]     r_sh;
    logic [ANCHO_BC-1:0]  r_cnt;
    logic [ANCHO-1:0]     r_dato;
    logic                 r_dato_valido;
    logic                 r_fin_trama;
    logic                 r_trama_incompleta;
    logic [ANCHO_CNT-1:0] r_num_palabras;
    logic                 r_desborde;

    logic                 w_inicio;
    logic                 w_captura;
    logic                 w_cierre;
    logic                 w_completa;
    logic                 w_acepta;
    logic                 w_descarta;
    logic [ANCHO-1:0]     w_palabra;

    always_ff @(posedge clk) begin
        if (!rst) r_estado <= ESPERA;
        else      r_estado <= w_estado_sig;
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            ESPERA:  if (bus.valido)  w_estado_sig = RECIBE;
            RECIBE:  if (!bus.valido) w_estado_sig = FIN;
            FIN:     w_estado_sig = ESPERA;
            default: w_estado_sig = ESPERA;
        endcase
    end

    always_comb begin
        w_inicio   = r_estado[0] & bus.valido;
        w_captura  = r_estado[1] & bus.valido;
        w_cierre   = r_estado[1] & ~bus.valido;
        w_completa = w_captura & (r_cnt == BC_ULT);
        w_palabra  = {r_sh[ANCHO-2:0], bus.s_in};
        // A finished word is kept only if the output slot is empty or being drained now.
        w_acepta   = w_completa & (~r_dato_valido | bus.listo);
        w_descarta = w_completa & r_dato_valido & ~bus.listo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh               <= '0;
            r_cnt              <= '0;
            r_dato             <= '0;
            r_dato_valido      <= 1'b0;
            r_fin_trama        <= 1'b0;
            r_trama_incompleta <= 1'b0;
            r_num_palabras     <= '0;
            r_desborde         <= 1'b0;
        end else begin
            r_fin_trama        <= w_cierre;
            r_trama_incompleta <= w_cierre & (r_cnt != '0);

            if (w_inicio) begin
                r_sh  <= {{(ANCHO-1){1'b0}}, bus.s_in};
                r_cnt <= ANCHO_BC'(1);
            end else if (w_captura) begin
                r_sh  <= w_palabra;
                r_cnt <= w_completa ? '0 : r_cnt + ANCHO_BC'(1);
            end else if (r_estado[2]) begin
                r_sh  <= '0;
                r_cnt <= '0;
            end

            if (w_inicio)
                r_num_palabras <= '0;
            else if (w_completa && (r_num_palabras != '1))
                r_num_palabras <= r_num_palabras + ANCHO_CNT'(1);

            if (w_acepta) begin
                r_dato        <= w_palabra;
                r_dato_valido <= 1'b1;
            end else if (r_dato_valido && bus.listo) begin
                r_dato_valido <= 1'b0;
            end

            if (w_descarta) r_desborde <= 1'b1;
        end
    end

    assign bus.dato             = r_dato;
    assign bus.dato_valido      = r_dato_valido;
    assign bus.fin_trama        = r_fin_trama;
    assign bus.trama_incompleta = r_trama_incompleta;
    assign bus.num_palabras     = r_num_palabras;
    assign bus.desborde         = r_desborde;
endmodule

// File: tb/tb_deser_trama.sv
// Bench for deser_trama: frames driven bit by bit, accepted words queued as expected
// output and popped when the DUT presents a new word.
module tb_deser_trama;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deser_trama_if bus ();
    deser_trama dut (.clk(clk), .rst(rst), .bus(bus));

    int         errores = 0;
    int         total   = 0;
    logic       m_dv    = 1'b0;
    logic       m_ovf   = 1'b0;
    logic [7:0] sb[$];

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // One clock edge with the current inputs; updates the output-slot model first.
    task automatic flanco(input logic comp, input logic [7:0] w);
        if (!rst) begin
            m_dv  = 1'b0;
            m_ovf = 1'b0;
            sb.delete();
        end else if (comp) begin
            if (!m_dv || bus.listo) begin
                m_dv = 1'b1;
                sb.push_back(w);
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_dv && bus.listo) begin
            m_dv = 1'b0;
        end
        @(posedge clk);
        #1;
        verifica("dato_valido", bus.dato_valido, m_dv);
        verifica("desborde", bus.desborde, m_ovf);
    endtask

    task automatic trama(input logic [63:0] bits, input int n, input logic [63:0] lst,
                         input logic lst_fin, input logic val_fin);
        for (int i = 0; i < n; i++) begin
            bus.valido = 1'b1;
            bus.s_in   = bits[n-1-i];
            bus.listo  = lst[i];
            flanco(((i + 1) % 8) == 0, 8'(bits >> (n - 1 - i)));
        end
        bus.valido = 1'b0;
        bus.s_in   = 1'b1;
        bus.listo  = lst_fin;
        flanco(1'b0, 8'h00);
        verifica("fin_trama", bus.fin_trama, 1'b1);
        verifica("trama_incompleta", bus.trama_incompleta, 32'((n % 8) != 0));
        verifica("num_palabras", bus.num_palabras, 32'(n / 8));
        bus.valido = val_fin;
        bus.s_in   = 1'b0;
        flanco(1'b0, 8'h00);
        verifica("fin_trama_baja", bus.fin_trama, 1'b0);
        verifica("incompleta_baja", bus.trama_incompleta, 1'b0);
    endtask

    always begin : monitor
        logic pdv, plis, prst;
        @(posedge clk);
        pdv  = bus.dato_valido;
        plis = bus.listo;
        prst = rst;
        #1;
        if (prst && bus.dato_valido && (!pdv || plis)) begin
            if (sb.size() == 0) verifica("palabra_inesperada", 32'(sb.size()), 32'd1);
            else                verifica("dato", bus.dato, sb.pop_front());
        end
    end

    task automatic salidas_cero(input string tag);
        verifica({tag, "_dato"}, bus.dato, 8'h00);
        verifica({tag, "_dv"}, bus.dato_valido, 1'b0);
        verifica({tag, "_fin"}, bus.fin_trama, 1'b0);
        verifica({tag, "_inc"}, bus.trama_incompleta, 1'b0);
        verifica({tag, "_num"}, bus.num_palabras, 8'h00);
        verifica({tag, "_desb"}, bus.desborde, 1'b0);
    endtask

    initial begin
        bus.valido = 1'b0;
        bus.s_in   = 1'b0;
        bus.listo  = 1'b0;
        flanco(1'b0, 8'h00);
        flanco(1'b0, 8'h00);
        salidas_cero("reset");
        rst = 1'b1;
        flanco(1'b0, 8'h00);

        // two full words, consumer always ready
        trama(64'hA53C, 16, '1, 1'b1, 1'b0);
        // partial word: 0xA5 then 101
        trama(64'h52D, 11, '1, 1'b1, 1'b0);
        // ready only on the edge completing the second word
        trama(64'hA53C, 16, 64'h8000, 1'b1, 1'b0);
        // backpressure throughout, second word dropped
        trama(64'hA53C, 16, '0, 1'b0, 1'b0);
        verifica("dato_retenido", bus.dato, 8'hA5);
        bus.listo = 1'b1;
        flanco(1'b0, 8'h00);
        bus.listo = 1'b0;
        verifica("desborde_pegado", bus.desborde, 1'b1);

        // reset mid-frame after 5 bits
        for (int i = 0; i < 5; i++) begin
            bus.valido = 1'b1;
            bus.s_in   = i[0];
            flanco(1'b0, 8'h00);
        end
        rst = 1'b0;
        flanco(1'b0, 8'h00);
        salidas_cero("reset_medio");
        rst        = 1'b1;
        bus.valido = 1'b0;
        bus.listo  = 1'b1;
        flanco(1'b0, 8'h00);

        // short frame whose FIN cycle sees valido=1 with s_in=0, then 0xFF
        trama(64'h5, 3, '1, 1'b1, 1'b1);
        trama(64'hFF, 8, '1, 1'b1, 1'b0);
        verifica("dato_ff", bus.dato, 8'hFF);
        verifica("cola_vacia", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errores, total);
        $finish;
    end
endmodule
